// File: rtl/btn_press_gen_if.sv
// Request/status bundle between the press sequencer and btn_press_gen.
// The master side issues press requests and aborts; the slave side
// drives the button net and reports its progress.
interface btn_press_gen_if;
    logic i_req_short;   // short-press request
    logic i_req_long;    // long/force-press request, wins over short
    logic i_abort;       // cut an active press short
    logic o_btn_n;       // button drive, 0 = pressed
    logic o_busy;        // press or release gap in progress
    logic o_long;        // current press/gap belongs to a long press
    logic o_done;        // one-cycle pulse at the end of the release gap
    logic o_req_drop;    // one-cycle pulse: request seen while busy, discarded

    modport master (
        output i_req_short,
        output i_req_long,
        output i_abort,
        input  o_btn_n,
        input  o_busy,
        input  o_long,
        input  o_done,
        input  o_req_drop
    );

    modport slave (
        input  i_req_short,
        input  i_req_long,
        input  i_abort,
        output o_btn_n,
        output o_busy,
        output o_long,
        output o_done,
        output o_req_drop
    );
endinterface

// File: rtl/btn_press_gen.sv
// Timed active-low button-press generator. A request in IDLE drives the
// button low for SHORT_CYCLES or LONG_CYCLES clocks, then holds it released
// for GAP_CYCLES clocks before pulsing o_done. One down-counter times both
// the press and the gap; every output comes straight from a register.
module btn_press_gen #(
    parameter int SHORT_CYCLES = 6554,
    parameter int LONG_CYCLES  = 131072,
    parameter int GAP_CYCLES   = 3277,
    parameter int CNT_W        = 18
) (
    input  logic           i_clk_32k,
    input  logic           i_rst_n,
    btn_press_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_btn_n;
    logic             w_btn_n_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_long;
    logic             w_long_next;
    logic             r_done;
    logic             w_done_next;
    logic             r_req_drop;
    logic             w_req_drop_next;

    logic             w_any_req;
    logic             w_cnt_zero;

    assign w_any_req  = bus.i_req_short | bus.i_req_long;
    assign w_cnt_zero = (r_cnt == '0);

    // State, counter and output registers; reset releases the button at once.
    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_btn_n    <= 1'b1;
            r_busy     <= 1'b0;
            r_long     <= 1'b0;
            r_done     <= 1'b0;
            r_req_drop <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_btn_n    <= w_btn_n_next;
            r_busy     <= w_busy_next;
            r_long     <= w_long_next;
            r_done     <= w_done_next;
            r_req_drop <= w_req_drop_next;
        end
    end

    // Next-state, counter and output decode; levels hold unless changed.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_btn_n_next    = r_btn_n;
        w_busy_next     = r_busy;
        w_long_next     = r_long;
        w_done_next     = 1'b0;
        // Requests arriving while busy are flagged and then forgotten.
        w_req_drop_next = (r_state != ST_IDLE) && w_any_req;

        case (r_state)
            ST_IDLE: begin
                if (bus.i_req_long) begin
                    w_state_next = ST_ASSERT;
                    w_cnt_next   = LONG_LOAD;
                    w_btn_n_next = 1'b0;
                    w_busy_next  = 1'b1;
                    w_long_next  = 1'b1;
                end else if (bus.i_req_short) begin
                    w_state_next = ST_ASSERT;
                    w_cnt_next   = SHORT_LOAD;
                    w_btn_n_next = 1'b0;
                    w_busy_next  = 1'b1;
                    w_long_next  = 1'b0;
                end
            end

            ST_ASSERT: begin
                // Abort and natural expiry both start a full release gap.
                if (bus.i_abort || w_cnt_zero) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = GAP_LOAD;
                    w_btn_n_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end

            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_long_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_btn_n_next = 1'b1;
                w_busy_next  = 1'b0;
                w_long_next  = 1'b0;
            end
        endcase
    end

    assign bus.o_btn_n    = r_btn_n;
    assign bus.o_busy     = r_busy;
    assign bus.o_long     = r_long;
    assign bus.o_done     = r_done;
    assign bus.o_req_drop = r_req_drop;

endmodule

// File: doc/btn_press_gen.md
# btn_press_gen

Generates a timed active-low button-press pulse on a board-level button net; it is the CPLD-side transmitter for a debounced button-press detector. Firmware/sequencing logic issues a short-press or long-press request. The block drives the button output low for a programmed number of 32 kHz cycles, then enforces a release gap and reports completion. It serves power and VGA button emulation toward the chipset and the companion press detector.

## Interface
- SHORT_CYCLES, 6554: low-time of a short press in clk cycles (~200 ms at 32.768 kHz); must be ≥1.
- LONG_CYCLES, 131072: low-time of a long/force press (~4 s); must be ≥1.
- GAP_CYCLES, 3277: minimum released time after any press (~100 ms); must be ≥1.
- CNT_W, 18: down-counter width; must hold max(SHORT_CYCLES, LONG_CYCLES, GAP_CYCLES) − 1.
- i_clk_32k  in  1  32 kHz clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_short  in  1  short-press request; sampled only in IDLE; a level held high retriggers after each completion.
- i_req_long  in  1  long-press request; sampled only in IDLE; wins over i_req_short.
- i_abort  in  1  ends an active press early; effective only in ASSERT.
- o_btn_n  out  1  button drive, registered; 0 = pressed.
- o_busy  out  1  high in ASSERT and GAP.
- o_long  out  1  high while the current ASSERT/GAP belongs to a long press.
- o_done  out  1  one-cycle pulse when GAP completes.
- o_req_drop  out  1  one-cycle pulse when any request is seen high while busy.

## Operation
- States: IDLE, ASSERT, GAP. Single CNT_W-bit down-counter cnt.
- IDLE: if i_req_long → ASSERT, cnt ← LONG_CYCLES−1, o_long ← 1. Else if i_req_short → ASSERT, cnt ← SHORT_CYCLES−1, o_long ← 0. o_btn_n ← 0 on entry. i_abort is ignored.
- ASSERT: if i_abort → GAP, cnt ← GAP_CYCLES−1, o_btn_n ← 1. Else if cnt == 0 → same transition. Else cnt ← cnt−1.
- GAP: if cnt == 0 → IDLE, o_done ← 1, o_busy ← 0, o_long ← 0. Else cnt ← cnt−1. i_abort is ignored.
- o_req_drop ← 1 for one cycle when state ≠ IDLE and (i_req_short | i_req_long). Dropped requests are not queued.
- Counter never wraps: decrement only when cnt ≠ 0. The state always leaves at 0.
- Reset (asynchronous, any state, including mid-press): state IDLE, cnt 0, o_btn_n 1, o_busy 0, o_long 0, o_done 0, o_req_drop 0. Any press in progress releases immediately with no gap.

## Timing
- Request high before edge k, in IDLE → o_btn_n = 0 and o_busy = 1 from edge k.
- o_btn_n stays low for exactly W cycles (W = SHORT_CYCLES or LONG_CYCLES) and returns high at edge k+W.
- GAP spans edges k+W … k+W+GAP_CYCLES−1. At edge k+W+GAP_CYCLES, o_done = 1 and o_busy = 0 for one cycle.
- A request high during the o_done cycle is accepted at the next edge. Minimum press period is therefore W+GAP_CYCLES+1 cycles.
- Abort sampled at edge j while in ASSERT → o_btn_n = 1 from edge j. The full GAP_CYCLES follows. o_done is still issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: SHORT_CYCLES=4, LONG_CYCLES=10, GAP_CYCLES=3.
- **Short press.** Reset, then one-cycle i_req_short at edge 5. Required: o_btn_n low during edges 5–8, high at edge 9. o_busy high during edges 5–11. o_done pulses at edge 12 only. o_long stays 0.
- **Long priority.** i_req_short and i_req_long both high at edge 5. Required: o_long = 1, o_btn_n low for exactly 10 cycles, o_done at edge 18.
- **Abort.** Long press started at edge 5, i_abort at edge 8. Required: o_btn_n high from edge 8, o_done at edge 11. i_abort pulsed in IDLE or GAP has no effect.
- **Drop while busy.** During a short press, i_req_long pulses at edge 7 and edge 10. Required: o_req_drop pulses at edges 7 and 10, no second press, o_done at edge 12.
- **Back-to-back.** i_req_short held high continuously. Required: presses start at edges 5, 13, 21 (8-cycle period), o_done at edges 12 and 20. o_req_drop pulses every busy cycle.
- **Reset mid-press.** Assert i_rst_n low asynchronously at mid-ASSERT. Required: o_btn_n = 1 and o_busy = 0 immediately. After release, a new i_req_short produces a full 4-cycle press.
